// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Holds the operation encoding, the controller state encoding and the
// default operand width used by muldiv_unit and muldiv_sign_adj.
package muldiv_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_sign_adj.sv
// muldiv_sign_adj: two's-complement wrapper around the unsigned datapath.
// Converts raw operands to magnitudes on the way in, and on the way out
// applies the result/remainder signs and flags signed overflow.
// Only instantiated when MULDIV_SIGNED_EN is defined.
module muldiv_sign_adj
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_mag_o,
    output logic [WIDTH-1:0] b_mag_o,
    input  op_e              op_i,
    input  logic             sa_i,
    input  logic             sb_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             ovf_o
);

    // Magnitude of the most negative value, i.e. 2^(WIDTH-1).
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_if(input logic s, input logic [WIDTH-1:0] v);
        return s ? ('0 - v) : v;
    endfunction

    logic neg_res;

    assign a_mag_o = neg_if(a_i[WIDTH-1], a_i);
    assign b_mag_o = neg_if(b_i[WIDTH-1], b_i);
    assign neg_res = sa_i ^ sb_i;

    // Re-apply signs to the unsigned result and decide signed overflow.
    always_comb begin
        res_o = neg_if(neg_res, lo_i);
        if (op_i == OP_MUL) begin
            rem_o = '0;
            // A negative product may reach -2^(WIDTH-1); a positive one only 2^(WIDTH-1)-1.
            ovf_o = (hi_i != '0) || (neg_res ? (lo_i > MIN_MAG) : lo_i[WIDTH-1]);
        end else begin
            // Remainder follows the dividend; only most-negative / -1 can overflow.
            rem_o = neg_if(sa_i, hi_i);
            ovf_o = !neg_res && lo_i[WIDTH-1];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider.
// One step per cycle for WIDTH cycles, results registered in DONE.
// Optional feature macro MULDIV_SIGNED_EN: two's-complement operands
// (magnitude datapath plus sign adjustment in muldiv_sign_adj).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             muldiv_err,
    output logic             div_by_zero
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] hi_q, lo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, err_q, dbz_q;
    logic [WIDTH-1:0] result_q, remainder_q;

    // hi/lo hold {product high, product low} or {partial remainder, quotient}.
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] fin_res, fin_rem;
    logic             fin_ovf;

`ifdef MULDIV_SIGNED_EN
    logic sa_q, sb_q;

    muldiv_sign_adj #(.WIDTH(WIDTH)) u_sign_adj (
        .a_i     (a),
        .b_i     (b),
        .a_mag_o (a_mag),
        .b_mag_o (b_mag),
        .op_i    (op_q),
        .sa_i    (sa_q),
        .sb_i    (sb_q),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .res_o   (fin_res),
        .rem_o   (fin_rem),
        .ovf_o   (fin_ovf)
    );
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign fin_res = lo_q;
    assign fin_rem = (op_q == OP_DIV) ? hi_q : '0;
    assign fin_ovf = (op_q == OP_MUL) && (hi_q != '0);
`endif

    // One multiply or divide iteration computed from the current datapath state.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == S_MUL) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, dvs_q}) begin
            hi_d = WIDTH'(div_shift - {1'b0, dvs_q});
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Controller: accepts a request in IDLE, iterates, and registers the outcome in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            hi_q        <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dbz_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
`ifdef MULDIV_SIGNED_EN
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_e'(op);
                        hi_q   <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef MULDIV_SIGNED_EN
                        sa_q   <= a[WIDTH-1];
                        sb_q   <= b[WIDTH-1];
`endif
                        if (op_e'(op) == OP_MUL) begin
                            dvs_q   <= a_mag;
                            lo_q    <= b_mag;
                            state_q <= S_MUL;
                        end else if (b == '0) begin
                            // Divide-by-zero: keep the raw dividend for the remainder output.
                            dvs_q   <= '0;
                            lo_q    <= a;
                            state_q <= S_DONE;
                        end else begin
                            dvs_q   <= b_mag;
                            lo_q    <= a_mag;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if ((op_q == OP_DIV) && (dvs_q == '0)) begin
                        result_q    <= '1;
                        remainder_q <= lo_q;
                        err_q       <= 1'b1;
                        dbz_q       <= 1'b1;
                    end else begin
                        result_q    <= fin_res;
                        remainder_q <= fin_rem;
                        err_q       <= fin_ovf;
                        dbz_q       <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign remainder   = remainder_q;
    assign muldiv_err  = err_q;
    assign div_by_zero = dbz_q;

endmodule
